// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
//   "Simon" memory game sequencer. Each round appends one pseudo-random button
//   to a sequence. It plays the whole sequence back, then checks that the player
//   repeats it button by button. Every output is a register.
//
// Ports
//   clk             in   game tick clock; all state changes on the rising edge
//   reset           in   asynchronous, active-high; forces IDLE, outputs 0
//   start           in   begins a new game (only honoured in IDLE/OVER/WON)
//   player_num      in   [BW]  index of the button the player holds
//   player_pressed  in   high while a player button is held (level)
//   simon_turn      out  high while the sequence is being played back
//   simon_num       out  [BW] button index being shown
//   simon_pressed   out  high while simon_num is shown pressed
//   level           out  [LW] current sequence length (final score in OVER/WON)
//   game_over       out  high after a wrong entry
//   game_won        out  high after a correct MAX_LEN round
//
// Configuration macro
//   SIMON_SPEEDUP_EN  when defined, playback on/off times halve every 8 levels
//                     (never below 4 ticks); otherwise they are constant.
// -----------------------------------------------------------------------------
module simon_sequencer #(
  parameter int          NUM_BTN   = 4,
  parameter int          MAX_LEN   = 32,
  parameter int          ON_TICKS  = 30,
  parameter int          OFF_TICKS = 30,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         BW        = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
  localparam int         LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [BW-1:0] player_num,
  input  logic          player_pressed,
  output logic          simon_turn,
  output logic [BW-1:0] simon_num,
  output logic          simon_pressed,
  output logic [LW-1:0] level,
  output logic          game_over,
  output logic          game_won
);

  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > 4) ? ON_TICKS : 4)
                                               : ((OFF_TICKS > 4) ? OFF_TICKS : 4);
  localparam int TW   = $clog2(MAXT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_OFF,
    S_SHOW_ON,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_CHECK,
    S_OVER,
    S_WON
  } state_t;

  state_t        r_state, w_state_n;
  logic [15:0]   r_lfsr;
  logic [LW-1:0] r_index, w_index_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic          r_press_q;
  logic [BW-1:0] r_player_num, w_player_num_n;
  logic          r_simon_turn, w_simon_turn_n;
  logic [BW-1:0] r_simon_num, w_simon_num_n;
  logic          r_simon_pressed, w_simon_pressed_n;
  logic [LW-1:0] r_level, w_level_n;
  logic          r_game_over, w_game_over_n;
  logic          r_game_won, w_game_won_n;

  logic [BW-1:0] r_mem [MAX_LEN];
  logic          w_mem_we;
  logic [BW-1:0] w_mem_rd;
  logic [BW-1:0] w_step;
  logic          w_lfsr_fb;
  logic          w_rise;
  logic          w_last;
  logic [TW-1:0] w_on_dur, w_off_dur;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_step    = BW'(r_lfsr % 16'(NUM_BTN));
  assign w_mem_rd  = r_mem[r_index[IW-1:0]];
  // Press is a registered 0->1 edge, so a button held over from playback
  // has to be released and pressed again before it counts.
  assign w_rise    = player_pressed && !r_press_q;
  assign w_last    = (r_index == r_level - 1'b1);

`ifdef SIMON_SPEEDUP_EN
  // Halve the duration every 8 levels, floor at 4 ticks.
  function automatic logic [TW-1:0] f_dur(input int base, input logic [LW-1:0] lvl);
    int sh;
    int v;
    sh = (lvl == '0) ? 0 : (int'(lvl - 1'b1) >> 3);
    v  = base >> sh;
    if (v < 4) v = 4;
    return TW'(v);
  endfunction

  assign w_on_dur  = f_dur(ON_TICKS, r_level);
  assign w_off_dur = f_dur(OFF_TICKS, r_level);
`else
  assign w_on_dur  = TW'(ON_TICKS);
  assign w_off_dur = TW'(OFF_TICKS);
`endif

  always_comb begin
    w_state_n         = r_state;
    w_index_n         = r_index;
    w_tick_n          = r_tick;
    w_player_num_n    = r_player_num;
    w_simon_turn_n    = r_simon_turn;
    w_simon_num_n     = r_simon_num;
    w_simon_pressed_n = r_simon_pressed;
    w_level_n         = r_level;
    w_game_over_n     = r_game_over;
    w_game_won_n      = r_game_won;
    w_mem_we          = 1'b0;

    case (r_state)
      S_IDLE, S_OVER, S_WON: begin
        if (start) begin
          w_state_n     = S_ADD;
          w_level_n     = '0;
          w_game_over_n = 1'b0;
          w_game_won_n  = 1'b0;
        end
      end

      S_ADD: begin
        w_mem_we          = 1'b1;
        w_level_n         = r_level + 1'b1;
        w_index_n         = '0;
        w_tick_n          = '0;
        w_simon_turn_n    = 1'b1;
        w_simon_pressed_n = 1'b0;
        w_state_n         = S_SHOW_OFF;
      end

      S_SHOW_OFF: begin
        if (r_tick == w_off_dur - 1'b1) begin
          w_tick_n          = '0;
          w_simon_num_n     = w_mem_rd;
          w_simon_pressed_n = 1'b1;
          w_state_n         = S_SHOW_ON;
        end else begin
          w_tick_n = r_tick + 1'b1;
        end
      end

      S_SHOW_ON: begin
        if (r_tick == w_on_dur - 1'b1) begin
          w_tick_n          = '0;
          w_simon_pressed_n = 1'b0;
          if (w_last) begin
            w_index_n      = '0;
            w_simon_turn_n = 1'b0;
            w_state_n      = S_WAIT_PRESS;
          end else begin
            w_index_n = r_index + 1'b1;
            w_state_n = S_SHOW_OFF;
          end
        end else begin
          w_tick_n = r_tick + 1'b1;
        end
      end

      S_WAIT_PRESS: begin
        if (w_rise) begin
          w_player_num_n = player_num;
          w_state_n      = S_WAIT_RELEASE;
        end
      end

      S_WAIT_RELEASE: begin
        // Track the button while held; the value seen last before release wins.
        if (player_pressed) begin
          w_player_num_n = player_num;
        end else begin
          w_state_n = S_CHECK;
        end
      end

      S_CHECK: begin
        if (r_player_num != w_mem_rd) begin
          w_game_over_n = 1'b1;
          w_state_n     = S_OVER;
        end else if (!w_last) begin
          w_index_n = r_index + 1'b1;
          w_state_n = S_WAIT_PRESS;
        end else if (r_level == LW'(MAX_LEN)) begin
          w_game_won_n = 1'b1;
          w_state_n    = S_WON;
        end else begin
          w_state_n = S_ADD;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_lfsr          <= SEED;
      r_index         <= '0;
      r_tick          <= '0;
      r_press_q       <= 1'b0;
      r_player_num    <= '0;
      r_simon_turn    <= 1'b0;
      r_simon_num     <= '0;
      r_simon_pressed <= 1'b0;
      r_level         <= '0;
      r_game_over     <= 1'b0;
      r_game_won      <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_lfsr          <= {w_lfsr_fb, r_lfsr[15:1]};
      r_index         <= w_index_n;
      r_tick          <= w_tick_n;
      r_press_q       <= player_pressed;
      r_player_num    <= w_player_num_n;
      r_simon_turn    <= w_simon_turn_n;
      r_simon_num     <= w_simon_num_n;
      r_simon_pressed <= w_simon_pressed_n;
      r_level         <= w_level_n;
      r_game_over     <= w_game_over_n;
      r_game_won      <= w_game_won_n;
    end
  end

  // Sequence storage is not reset: only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_level[IW-1:0]] <= w_step;
    end
  end

  assign simon_turn    = r_simon_turn;
  assign simon_num     = r_simon_num;
  assign simon_pressed = r_simon_pressed;
  assign level         = r_level;
  assign game_over     = r_game_over;
  assign game_won      = r_game_won;

endmodule
